// File: rtl/mptw_mem_arbiter.sv
// Round-robin arbiter that shares one memory master port among NUM_REQ requesters.
// An in-order tag FIFO of winner IDs routes each response back to its issuer.
module mptw_mem_arbiter #(
    parameter int unsigned NUM_REQ         = 3,
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned ADDR_WIDTH      = 64,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic                                    flush_i,
    input  logic [NUM_REQ-1:0]                      slave_mem_req,
    output logic [NUM_REQ-1:0]                      slave_mem_gnt,
    output logic [NUM_REQ-1:0]                      slave_mem_valid,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]      slave_mem_addr,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]      slave_mem_wdata,
    input  logic [NUM_REQ-1:0]                      slave_mem_we,
    input  logic [NUM_REQ-1:0][DATA_WIDTH/8-1:0]    slave_mem_be,
    output logic [NUM_REQ-1:0][DATA_WIDTH-1:0]      slave_mem_rdata,
    output logic [NUM_REQ-1:0]                      slave_mem_error,
    output logic                                    master_mem_req,
    input  logic                                    master_mem_gnt,
    input  logic                                    master_mem_valid,
    output logic [ADDR_WIDTH-1:0]                   master_mem_addr,
    output logic [DATA_WIDTH-1:0]                   master_mem_wdata,
    output logic                                    master_mem_we,
    output logic [DATA_WIDTH/8-1:0]                 master_mem_be,
    input  logic [DATA_WIDTH-1:0]                   master_mem_rdata,
    input  logic                                    master_mem_error,
    output logic [$clog2(MAX_OUTSTANDING):0]        outstanding_o,
    output logic                                    idle_o,
    output logic                                    protocol_error_o
);

    localparam int unsigned IDW  = $clog2(NUM_REQ);
    localparam int unsigned PTRW = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CNTW = PTRW + 1;

    logic [IDW-1:0]  rr_q;
    logic            lock_q;
    logic [IDW-1:0]  lock_id_q;
    logic [IDW-1:0]  fifo_q [MAX_OUTSTANDING];
    logic [PTRW-1:0] head_q, tail_q;
    logic [CNTW-1:0] count_q;
    logic            proto_err_q;

    logic [NUM_REQ-1:0] eligible;
    logic               full;
    logic               empty;
    logic [IDW-1:0]     rr_sel;
    logic [IDW-1:0]     sel;
    logic               gnt_fire;
    logic               pop;
    logic [IDW-1:0]     head_id;

    assign full     = (count_q == CNTW'(MAX_OUTSTANDING));
    assign empty    = (count_q == '0);
    assign eligible = slave_mem_req & ~{NUM_REQ{full}};
    assign head_id  = fifo_q[head_q];

    always_comb begin : p_rr_search
        logic found;
        found  = 1'b0;
        rr_sel = rr_q;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            if (!found && slave_mem_req[(int'(rr_q) + k) % int'(NUM_REQ)]) begin
                found  = 1'b1;
                rr_sel = IDW'((int'(rr_q) + k) % int'(NUM_REQ));
            end
        end
    end

    // A waiting (locked) request must stay asserted even under flush or full.
    always_comb begin
        master_mem_req = 1'b0;
        sel            = rr_sel;
        if (lock_q) begin
            master_mem_req = 1'b1;
            sel            = lock_id_q;
        end else if (!flush_i && !full) begin
            master_mem_req = |eligible;
        end
    end

    always_comb begin
        master_mem_addr  = '0;
        master_mem_wdata = '0;
        master_mem_we    = 1'b0;
        master_mem_be    = '0;
        if (master_mem_req) begin
            master_mem_addr  = slave_mem_addr[sel];
            master_mem_wdata = slave_mem_wdata[sel];
            master_mem_we    = slave_mem_we[sel];
            master_mem_be    = slave_mem_be[sel];
        end
    end

    assign gnt_fire = master_mem_req & master_mem_gnt;
    assign pop      = master_mem_valid & ~empty;

    always_comb begin
        slave_mem_gnt   = '0;
        slave_mem_valid = '0;
        slave_mem_error = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            slave_mem_gnt[i]   = gnt_fire && (sel == IDW'(i));
            slave_mem_valid[i] = pop && (head_id == IDW'(i));
            slave_mem_error[i] = pop && (head_id == IDW'(i)) && master_mem_error;
        end
    end

    assign slave_mem_rdata  = {NUM_REQ{master_mem_rdata}};
    assign outstanding_o    = count_q;
    assign idle_o           = ~master_mem_req & empty;
    assign protocol_error_o = proto_err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q        <= '0;
            lock_q      <= 1'b0;
            lock_id_q   <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            proto_err_q <= 1'b0;
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            if (master_mem_req && !master_mem_gnt) begin
                lock_q    <= 1'b1;
                lock_id_q <= sel;
            end else if (master_mem_gnt) begin
                lock_q <= 1'b0;
            end

            if (gnt_fire) begin
                fifo_q[tail_q] <= sel;
                tail_q         <= tail_q + 1'b1;
                rr_q           <= IDW'((int'(sel) + 1) % int'(NUM_REQ));
            end
            if (pop) begin
                head_q <= head_q + 1'b1;
            end

            case ({gnt_fire, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase

            if (master_mem_valid && empty) begin
                proto_err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mptw_mem_arbiter.sv
// Directed bench for mptw_mem_arbiter: inputs change on the falling edge,
// outputs are checked 1ns later, state advances on the rising edge.
module tb_mptw_mem_arbiter;

    localparam int NR = 3;
    localparam int DW = 64;
    localparam int AW = 64;
    localparam int MO = 4;

    logic                     clk_i = 1'b0;
    logic                     rst_ni;
    logic                     flush_i;
    logic [NR-1:0]            s_req;
    logic [NR-1:0]            s_gnt;
    logic [NR-1:0]            s_valid;
    logic [NR-1:0][AW-1:0]    s_addr;
    logic [NR-1:0][DW-1:0]    s_wdata;
    logic [NR-1:0]            s_we;
    logic [NR-1:0][DW/8-1:0]  s_be;
    logic [NR-1:0][DW-1:0]    s_rdata;
    logic [NR-1:0]            s_err;
    logic                     m_req;
    logic                     m_gnt;
    logic                     m_valid;
    logic [AW-1:0]            m_addr;
    logic [DW-1:0]            m_wdata;
    logic                     m_we;
    logic [DW/8-1:0]          m_be;
    logic [DW-1:0]            m_rdata;
    logic                     m_err;
    logic [$clog2(MO):0]      outstanding;
    logic                     idle;
    logic                     proto_err;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk_i = ~clk_i;

    mptw_mem_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .flush_i          (flush_i),
        .slave_mem_req    (s_req),
        .slave_mem_gnt    (s_gnt),
        .slave_mem_valid  (s_valid),
        .slave_mem_addr   (s_addr),
        .slave_mem_wdata  (s_wdata),
        .slave_mem_we     (s_we),
        .slave_mem_be     (s_be),
        .slave_mem_rdata  (s_rdata),
        .slave_mem_error  (s_err),
        .master_mem_req   (m_req),
        .master_mem_gnt   (m_gnt),
        .master_mem_valid (m_valid),
        .master_mem_addr  (m_addr),
        .master_mem_wdata (m_wdata),
        .master_mem_we    (m_we),
        .master_mem_be    (m_be),
        .master_mem_rdata (m_rdata),
        .master_mem_error (m_err),
        .outstanding_o    (outstanding),
        .idle_o           (idle),
        .protocol_error_o (proto_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    function automatic logic [63:0] oh(input int id);
        return 64'(1) << id;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ord_c [6] = '{2, 0, 1, 2, 0, 1};
        int ord_f [4] = '{2, 0, 1, 2};
        int ord_d [4] = '{0, 1, 2, 0};

        rst_ni  = 1'b0;
        flush_i = 1'b0;
        s_req   = '0;
        m_gnt   = 1'b0;
        m_valid = 1'b0;
        m_rdata = '0;
        m_err   = 1'b0;
        s_addr[0]  = 64'h0100; s_addr[1]  = 64'h1000; s_addr[2]  = 64'h2000;
        s_wdata[0] = 64'hA0;   s_wdata[1] = 64'hA1;   s_wdata[2] = 64'hA2;
        s_we       = 3'b010;
        s_be[0]    = 8'h0F;    s_be[1]    = 8'hF0;    s_be[2]    = 8'hFF;

        #3;
        chk("rst_mreq", 64'(m_req), 0);
        chk("rst_gnt", 64'(s_gnt), 0);
        chk("rst_valid", 64'(s_valid), 0);
        chk("rst_outst", 64'(outstanding), 0);
        chk("rst_idle", 64'(idle), 1);
        chk("rst_perr", 64'(proto_err), 0);

        @(negedge clk_i);
        rst_ni = 1'b1;

        // single requester 1
        s_req = 3'b010; m_gnt = 1'b1;
        #1;
        chk("single_mreq", 64'(m_req), 1);
        chk("single_addr", m_addr, 64'h1000);
        chk("single_wdata", m_wdata, 64'hA1);
        chk("single_we", 64'(m_we), 1);
        chk("single_be", 64'(m_be), 64'hF0);
        chk("single_gnt", 64'(s_gnt), 64'b010);
        chk("single_outst0", 64'(outstanding), 0);
        step();
        s_req = '0; m_gnt = 1'b0;
        #1;
        chk("single_outst1", 64'(outstanding), 1);
        chk("single_idle0", 64'(idle), 0);
        chk("single_addr_zero", m_addr, 0);
        step();
        m_valid = 1'b1; m_rdata = 64'hCAFE;
        #1;
        chk("single_valid", 64'(s_valid), 64'b010);
        chk("single_rdata", s_rdata[1], 64'hCAFE);
        step();
        m_valid = 1'b0;
        #1;
        chk("single_outst_end", 64'(outstanding), 0);
        chk("single_idle1", 64'(idle), 1);

        // contention, rr pointer is 2 here
        s_req = 3'b111; m_gnt = 1'b1;
        for (int k = 0; k < 6; k++) begin
            m_valid = (k > 0);
            #1;
            chk("cont_gnt", 64'(s_gnt), oh(ord_c[k]));
            if (k > 0) begin
                chk("cont_valid", 64'(s_valid), oh(ord_c[k-1]));
                chk("cont_outst", 64'(outstanding), 1);
            end
            step();
        end
        s_req = '0; m_gnt = 1'b0; m_valid = 1'b1;
        #1;
        chk("cont_last_valid", 64'(s_valid), oh(1));
        step();
        m_valid = 1'b0;
        #1;
        chk("cont_outst_end", 64'(outstanding), 0);

        // grant 2 once so the pointer returns to 0
        s_req = 3'b100; m_gnt = 1'b1;
        #1;
        chk("align_gnt", 64'(s_gnt), oh(2));
        step();
        s_req = '0; m_gnt = 1'b0; m_valid = 1'b1;
        #1;
        chk("align_valid", 64'(s_valid), oh(2));
        step();
        m_valid = 1'b0;

        // backpressure with lock; flush pulse while locked
        s_req = 3'b101;
        for (int k = 0; k < 5; k++) begin
            if (k == 1) s_req = 3'b111;
            flush_i = (k == 2);
            #1;
            chk("bp_addr", m_addr, 64'h0100);
            chk("bp_mreq", 64'(m_req), 1);
            chk("bp_gnt", 64'(s_gnt), 0);
            step();
        end
        flush_i = 1'b0; m_gnt = 1'b1;
        #1;
        chk("bp_gnt0", 64'(s_gnt), oh(0));
        step();
        s_req = 3'b110;
        #1;
        chk("bp_next_gnt", 64'(s_gnt), oh(1));
        chk("bp_next_addr", m_addr, 64'h1000);
        step();
        s_req = '0; m_gnt = 1'b0; m_valid = 1'b1;
        #1;
        chk("bp_valid0", 64'(s_valid), oh(0));
        step();
        #1;
        chk("bp_valid1", 64'(s_valid), oh(1));
        step();
        m_valid = 1'b0;

        // flush blocks unlocked arbitration
        flush_i = 1'b1; s_req = 3'b001;
        #1;
        chk("flush_mreq", 64'(m_req), 0);
        chk("flush_idle", 64'(idle), 1);
        flush_i = 1'b0; s_req = '0;

        // fill the tag FIFO, pointer is 2 here
        s_req = 3'b111; m_gnt = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("full_gnt", 64'(s_gnt), oh(ord_f[k]));
            step();
        end
        #1;
        chk("full_mreq", 64'(m_req), 0);
        chk("full_gnt_none", 64'(s_gnt), 0);
        chk("full_outst", 64'(outstanding), 4);
        m_valid = 1'b1;
        #1;
        chk("full_pop_mreq", 64'(m_req), 0);
        chk("full_pop_valid", 64'(s_valid), oh(2));
        step();
        m_valid = 1'b0;
        #1;
        chk("full_resume_mreq", 64'(m_req), 1);
        chk("full_resume_gnt", 64'(s_gnt), oh(0));
        chk("full_resume_outst", 64'(outstanding), 3);
        step();
        s_req = '0; m_gnt = 1'b0; m_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("full_drain", 64'(s_valid), oh(ord_d[k]));
            step();
        end
        m_valid = 1'b0;
        #1;
        chk("full_outst_end", 64'(outstanding), 0);

        // routing and error, grants to 2,0,1
        m_gnt = 1'b1;
        s_req = 3'b100; #1; chk("route_gnt2", 64'(s_gnt), oh(2)); step();
        s_req = 3'b001; #1; chk("route_gnt0", 64'(s_gnt), oh(0)); step();
        s_req = 3'b010; #1; chk("route_gnt1", 64'(s_gnt), oh(1)); step();
        s_req = '0; m_gnt = 1'b0;
        m_valid = 1'b1; m_err = 1'b0; m_rdata = 64'h1111;
        #1;
        chk("route_v2", 64'(s_valid), oh(2));
        chk("route_e2", 64'(s_err), 0);
        chk("route_d2", s_rdata[2], 64'h1111);
        step();
        m_err = 1'b1; m_rdata = 64'h2222;
        #1;
        chk("route_v0", 64'(s_valid), oh(0));
        chk("route_e0", 64'(s_err), oh(0));
        chk("route_d0", s_rdata[0], 64'h2222);
        step();
        m_err = 1'b0; m_rdata = 64'h3333;
        #1;
        chk("route_v1", 64'(s_valid), oh(1));
        chk("route_e1", 64'(s_err), 0);
        step();
        #1;
        chk("drop_valid", 64'(s_valid), 0);
        chk("drop_perr_before", 64'(proto_err), 0);
        step();
        m_valid = 1'b0;
        #1;
        chk("drop_perr_after", 64'(proto_err), 1);

        // two outstanding plus a held lock, then async reset
        m_gnt = 1'b1;
        s_req = 3'b001; #1; chk("prer_gnt0", 64'(s_gnt), oh(0)); step();
        s_req = 3'b010; #1; chk("prer_gnt1", 64'(s_gnt), oh(1)); step();
        s_req = 3'b100; m_gnt = 1'b0;
        #1;
        chk("prer_mreq", 64'(m_req), 1);
        step();
        #1;
        chk("prer_outst", 64'(outstanding), 2);
        #1;
        rst_ni = 1'b0; s_req = '0;
        #1;
        chk("arst_mreq", 64'(m_req), 0);
        chk("arst_idle", 64'(idle), 1);
        chk("arst_outst", 64'(outstanding), 0);
        chk("arst_perr", 64'(proto_err), 0);
        chk("arst_gnt", 64'(s_gnt), 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        s_req = 3'b111; m_gnt = 1'b1;
        #1;
        chk("post_rst_gnt", 64'(s_gnt), oh(0));
        step();
        s_req = '0; m_gnt = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mptw_mem_arbiter.md
Name: mptw_mem_arbiter

Overview:
- Shares one memory master port among NUM_REQ memory requesters, for example the MPT walker's walking-stage ports and the PLB refill port.
- Arbitrates round-robin and forwards the winner's request.
- Records the winner's ID in an in-order tag FIFO and routes each response back to the requester that issued it.
- Sits between the walker's memory ports and the system memory/interconnect adapter.

Parameters:
NUM_REQ, 3, number of requester ports (>=2)
DATA_WIDTH, 64, memory data width
ADDR_WIDTH, 64, memory address width
MAX_OUTSTANDING, 4, tag FIFO depth = max granted-but-unanswered requests (power of 2)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  stop issuing new (unlocked) requests while high
slave_mem_req  in  NUM_REQ  per-requester request
slave_mem_gnt  out  NUM_REQ  per-requester grant
slave_mem_valid  out  NUM_REQ  per-requester response valid
slave_mem_addr  in  NUM_REQ x ADDR_WIDTH  request address
slave_mem_wdata  in  NUM_REQ x DATA_WIDTH  write data
slave_mem_we  in  NUM_REQ  write enable
slave_mem_be  in  NUM_REQ x DATA_WIDTH/8  byte enables
slave_mem_rdata  out  NUM_REQ x DATA_WIDTH  response data (broadcast)
slave_mem_error  out  NUM_REQ  response error (per port, qualified by valid)
master_mem_req  out  1  forwarded request
master_mem_gnt  in  1  downstream grant
master_mem_valid  in  1  downstream response valid
master_mem_addr  out  ADDR_WIDTH  forwarded address
master_mem_wdata  out  DATA_WIDTH  forwarded write data
master_mem_we  out  1  forwarded write enable
master_mem_be  out  DATA_WIDTH/8  forwarded byte enables
master_mem_rdata  in  DATA_WIDTH  response data
master_mem_error  in  1  response error
outstanding_o  out  $clog2(MAX_OUTSTANDING)+1  tag FIFO occupancy
idle_o  out  1  no request pending and FIFO empty
protocol_error_o  out  1  sticky: response arrived with empty FIFO

Behaviour:

Memory protocol, on both sides:
- The requester holds req and its payload stable until gnt. gnt is a same-cycle accept.
- One response (valid) per accepted request, at least 1 cycle after gnt, strictly in order.

State:
- RR pointer rr_q.
- Lock register lock_q/lock_id_q.
- Tag FIFO of requester IDs: MAX_OUTSTANDING entries, head/tail wrap modulo depth, count register.

Arbitration (combinational):
- Eligible = slave_mem_req & ~full.
- If lock_q: sel = lock_id_q, and master_mem_req = 1 regardless of flush_i and full.
- Else, if flush_i = 1 or full: master_mem_req = 0.
- Otherwise sel = first index with req, searching from rr_q upward with wrap; master_mem_req = |eligible.
- master addr/wdata/we/be = payload of sel. When master_mem_req = 0, payload drives '0.
- slave_mem_gnt[i] = master_mem_gnt & master_mem_req & (sel == i).

Lock:
- If master_mem_req = 1 and master_mem_gnt = 0: lock_q <= 1, lock_id_q <= sel.
- On master_mem_gnt = 1: lock_q <= 0.
- The selection therefore never changes while a forwarded request is waiting, so the downstream protocol is never violated.

On grant (master_mem_req & master_mem_gnt):
- Push sel into the tail of the FIFO.
- rr_q <= (sel + 1) mod NUM_REQ.
- Zero added latency: grant-to-requester is the same cycle.

On master_mem_valid:
- If the FIFO is not empty: pop the head and assert slave_mem_valid[head] = 1 in the same cycle. slave_mem_error[head] = master_mem_error.
- slave_mem_rdata = master_mem_rdata on all ports; all other valid/error bits are 0.
- If the FIFO is empty: drop the response and set protocol_error_o = 1 (sticky until reset).

FIFO boundaries:
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Full blocks new arbitration even when a pop occurs in the same cycle. There is no valid-to-req combinational path.
- outstanding_o = count. idle_o = ~master_mem_req & (count == 0).

flush_i:
- Only blocks new unlocked arbitration.
- A locked request still completes, and outstanding responses are still routed.
- The walker waits for idle_o before reuse.

Reset (asynchronous, rst_ni = 0):
- rr_q = 0, lock_q = 0, FIFO empty, protocol_error_o = 0.
- All gnt/valid/req outputs are 0. outstanding_o = 0, idle_o = 1.
- Reset mid-operation discards in-flight tags. Downstream must be reset together.

Test Plan:
- Single requester: req[1] at addr 0x1000, gnt same cycle, valid 2 cycles later with rdata 0xCAFE -> slave_mem_gnt[1] pulses with the grant; slave_mem_valid[1] = 1 with rdata 0xCAFE; no other valid; outstanding goes 0->1->0.
- Contention: req[0..2] all high continuously, gnt always 1 -> grant order 0,1,2,0,1,2.
- Contention with rr_q = 2 after reset-free run -> requester 2 is served first.
- Backpressure: req[0] and req[2] high, gnt = 0 for 5 cycles while req[1] rises -> master_mem_addr stays at requester 0's address; after gnt, the next winner is 1.
- Full FIFO: MAX_OUTSTANDING = 4 grants issued with no valid -> master_mem_req = 0 and outstanding_o = 4; one valid restores issue on the following cycle.
- Routing and error: grants to 2,0,1, then 3 responses, the second with error = 1 -> valid to ports 2,0,1 in order; error only on port 0. A valid with empty FIFO -> protocol_error_o = 1.
- Reset: assert rst_ni = 0 with 2 outstanding and lock held -> all outputs return to reset values immediately; idle_o = 1.
